// File: rtl/pipe_collision_ctrl.sv
// rtl/pipe_collision_ctrl.sv - game supervisor: pipe scroll, collision detect, score, flight handshake
//
// Purpose:
//   Sits opposite the bird flight controller. Starts a game on a button
//   press, scrolls one pipe leftwards with an LFSR-chosen gap, detects
//   bird/pipe and bird/floor collisions, stops the flight controller on a
//   crash and keeps a saturating score of pipes passed.
//
// Ports:
//   Clk, reset                      clock, asynchronous active-high reset
//   BtnC                            debounced single-cycle press (start / acknowledge)
//   q_Initial, q_Flight, q_Stop     one-hot state of the flight controller
//   Bird_X_L/X_R/Y_T/Y_B            bird bounding box, inclusive
//   Start, Ack                      single-cycle pulses to the flight controller
//   Stop                            level to the flight controller
//   Pipe_X_L/X_R                    pipe horizontal extent, inclusive
//   Gap_Y_T/Y_B                     gap vertical extent, inclusive
//   Score                           pipes passed, saturating at 255
//   q_Idle, q_Run, q_Hit, q_Done    one-hot state of this block

module pipe_collision_ctrl #(
  parameter int unsigned PIPE_STEP = 4,
  parameter int unsigned PIPE_W    = 40,
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned GAP_MIN_Y = 100,
  parameter int unsigned GAP_H     = 120,
  parameter int unsigned FLOOR_Y   = 636,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       BtnC,
  input  logic       q_Initial,
  input  logic       q_Flight,
  input  logic       q_Stop,
  input  logic [9:0] Bird_X_L,
  input  logic [9:0] Bird_X_R,
  input  logic [9:0] Bird_Y_T,
  input  logic [9:0] Bird_Y_B,
  output logic       Start,
  output logic       Ack,
  output logic       Stop,
  output logic [9:0] Pipe_X_L,
  output logic [9:0] Pipe_X_R,
  output logic [9:0] Gap_Y_T,
  output logic [9:0] Gap_Y_B,
  output logic [7:0] Score,
  output logic       q_Idle,
  output logic       q_Run,
  output logic       q_Hit,
  output logic       q_Done
);

  localparam logic [9:0] X_START_L = 10'(SCREEN_W);
  localparam logic [9:0] X_START_R = 10'(SCREEN_W + PIPE_W - 1);
  localparam logic [9:0] STEP      = 10'(PIPE_STEP);
  localparam logic [9:0] GAP_MIN   = 10'(GAP_MIN_Y);
  localparam logic [9:0] GAP_SPAN  = 10'(GAP_H - 1);
  localparam logic [9:0] FLOOR     = 10'(FLOOR_Y);
  localparam logic [9:0] GAP_T_RST = GAP_MIN + {2'b00, LFSR_SEED};
  localparam logic [9:0] GAP_B_RST = GAP_T_RST + GAP_SPAN;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_RUN  = 4'b0010,
    S_HIT  = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic       ack_q, ack_d;
  logic       stop_q, stop_d;
  logic [9:0] pipe_l_q, pipe_l_d;
  logic [9:0] pipe_r_q, pipe_r_d;
  logic [9:0] gap_t_q, gap_t_d;
  logic [9:0] gap_b_q, gap_b_d;
  logic [7:0] score_q, score_d;
  logic       passed_q, passed_d;
  logic [7:0] lfsr_q, lfsr_d;

  logic       overlap_x;
  logic       outside_gap;
  logic       crash;
  logic       respawn;
  logic       score_hit;
  logic [9:0] new_gap_t;

  // The flight controller's Flight state carries no information this block needs.
  logic unused_q_flight;
  assign unused_q_flight = q_Flight;

  always_comb begin
    // Fibonacci LFSR, taps 8,6,5,4; a nonzero seed keeps it off the all-zero state.
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Collision terms use this cycle's registered pipe and the previous-cycle bird box.
    overlap_x   = (Bird_X_R >= pipe_l_q) && (Bird_X_L <= pipe_r_q);
    outside_gap = (Bird_Y_T < gap_t_q) || (Bird_Y_B > gap_b_q);
    crash       = (overlap_x && outside_gap) || (Bird_Y_B >= FLOOR);
    respawn     = pipe_r_q < STEP;
    score_hit   = (pipe_r_q < Bird_X_L) && !passed_q;
    new_gap_t   = GAP_MIN + {2'b00, lfsr_q};

    state_d  = state_q;
    start_d  = 1'b0;
    ack_d    = 1'b0;
    stop_d   = stop_q;
    pipe_l_d = pipe_l_q;
    pipe_r_d = pipe_r_q;
    gap_t_d  = gap_t_q;
    gap_b_d  = gap_b_q;
    score_d  = score_q;
    passed_d = passed_q;

    unique case (state_q)
      S_IDLE: begin
        pipe_l_d = X_START_L;
        pipe_r_d = X_START_R;
        score_d  = 8'd0;
        passed_d = 1'b0;
        stop_d   = 1'b0;
        if (BtnC && q_Initial) begin
          start_d = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (crash) begin
          // Pipe and score freeze on the crash cycle, even if a pass coincides.
          stop_d  = 1'b1;
          state_d = S_HIT;
        end else begin
          if (respawn) begin
            pipe_l_d = X_START_L;
            pipe_r_d = X_START_R;
            gap_t_d  = new_gap_t;
            gap_b_d  = new_gap_t + GAP_SPAN;
          end else begin
            pipe_l_d = pipe_l_q - STEP;
            pipe_r_d = pipe_r_q - STEP;
          end
          if (score_hit && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
          end
          // The passed flag belongs to the pipe on screen: a respawn starts a
          // fresh pipe, so it clears the flag even when the old pipe scores now.
          if (respawn) begin
            passed_d = 1'b0;
          end else if (score_hit) begin
            passed_d = 1'b1;
          end
        end
      end

      S_HIT: begin
        stop_d = 1'b1;
        if (q_Stop) begin
          stop_d  = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        stop_d = 1'b0;
        if (BtnC) begin
          ack_d    = 1'b1;
          state_d  = S_IDLE;
          pipe_l_d = X_START_L;
          pipe_r_d = X_START_R;
          score_d  = 8'd0;
          passed_d = 1'b0;
        end
      end

      default: begin
        // Corrupted state register: fall back to idle with reset-valued outputs.
        state_d  = S_IDLE;
        stop_d   = 1'b0;
        pipe_l_d = X_START_L;
        pipe_r_d = X_START_R;
        gap_t_d  = GAP_T_RST;
        gap_b_d  = GAP_B_RST;
        score_d  = 8'd0;
        passed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      ack_q    <= 1'b0;
      stop_q   <= 1'b0;
      pipe_l_q <= X_START_L;
      pipe_r_q <= X_START_R;
      gap_t_q  <= GAP_T_RST;
      gap_b_q  <= GAP_B_RST;
      score_q  <= 8'd0;
      passed_q <= 1'b0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      ack_q    <= ack_d;
      stop_q   <= stop_d;
      pipe_l_q <= pipe_l_d;
      pipe_r_q <= pipe_r_d;
      gap_t_q  <= gap_t_d;
      gap_b_q  <= gap_b_d;
      score_q  <= score_d;
      passed_q <= passed_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign Start    = start_q;
  assign Ack      = ack_q;
  assign Stop     = stop_q;
  assign Pipe_X_L = pipe_l_q;
  assign Pipe_X_R = pipe_r_q;
  assign Gap_Y_T  = gap_t_q;
  assign Gap_Y_B  = gap_b_q;
  assign Score    = score_q;
  assign q_Idle   = state_q[0];
  assign q_Run    = state_q[1];
  assign q_Hit    = state_q[2];
  assign q_Done   = state_q[3];

endmodule

// File: tb/tb_pipe_collision_ctrl.sv
// tb/tb_pipe_collision_ctrl.sv - randomized scoreboard bench for pipe_collision_ctrl

module tb_pipe_collision_ctrl;

  logic       Clk = 1'b0;
  logic       reset;
  logic       BtnC, q_Initial, q_Flight, q_Stop;
  logic [9:0] Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B;
  logic       Start, Ack, Stop;
  logic [9:0] Pipe_X_L, Pipe_X_R, Gap_Y_T, Gap_Y_B;
  logic [7:0] Score;
  logic       q_Idle, q_Run, q_Hit, q_Done;

  always #5 Clk = ~Clk;

  pipe_collision_ctrl dut (
    .Clk(Clk), .reset(reset), .BtnC(BtnC),
    .q_Initial(q_Initial), .q_Flight(q_Flight), .q_Stop(q_Stop),
    .Bird_X_L(Bird_X_L), .Bird_X_R(Bird_X_R), .Bird_Y_T(Bird_Y_T), .Bird_Y_B(Bird_Y_B),
    .Start(Start), .Ack(Ack), .Stop(Stop),
    .Pipe_X_L(Pipe_X_L), .Pipe_X_R(Pipe_X_R), .Gap_Y_T(Gap_Y_T), .Gap_Y_B(Gap_Y_B),
    .Score(Score), .q_Idle(q_Idle), .q_Run(q_Run), .q_Hit(q_Hit), .q_Done(q_Done)
  );

  typedef struct packed {
    logic       start;
    logic       ack;
    logic       stop;
    logic [9:0] pl;
    logic [9:0] pr;
    logic [9:0] gt;
    logic [9:0] gb;
    logic [7:0] score;
    logic [3:0] st;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_a, dummy;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: game phase 0 idle, 1 run, 2 hit, 3 done.
  int         m_st, m_pl, m_gt, m_score;
  bit         m_passed, m_start, m_ack, m_stop;
  logic [7:0] m_lfsr;

  // Flight-controller emulation: 0 initial, 1 flight, 2 stop.
  int fc, stop_wait;
  int mode, bx, cap, run_cyc, rst_at, games, total;

  task automatic model_reset();
    m_st = 0; m_pl = 640; m_lfsr = 8'hA5; m_gt = 100 + 165;
    m_score = 0; m_passed = 0; m_start = 0; m_ack = 0; m_stop = 0;
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.start = m_start; e.ack = m_ack; e.stop = m_stop;
    e.pl = 10'(m_pl); e.pr = 10'(m_pl + 39);
    e.gt = 10'(m_gt); e.gb = 10'(m_gt + 119);
    e.score = 8'(m_score);
    e.st = 4'(1 << m_st);
    return e;
  endfunction

  task automatic model_step();
    int         pr;
    int         xl, xr, yt, yb;
    bit         crash, scored;
    logic [7:0] nl;
    pr = m_pl + 39;
    xl = int'(Bird_X_L); xr = int'(Bird_X_R); yt = int'(Bird_Y_T); yb = int'(Bird_Y_B);
    nl = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    m_start = 0; m_ack = 0;
    case (m_st)
      0: begin
        m_pl = 640; m_score = 0; m_passed = 0;
        if (BtnC && q_Initial) begin m_start = 1; m_st = 1; end
      end
      1: begin
        crash = (xr >= m_pl && xl <= pr && (yt < m_gt || yb > m_gt + 119)) || yb >= 636;
        if (crash) begin
          m_stop = 1; m_st = 2;
        end else begin
          scored = (pr < xl) && !m_passed;
          if (scored) begin
            if (m_score < 255) m_score++;
            m_passed = 1;
          end
          if (pr < 4) begin
            m_pl = 640; m_gt = 100 + int'(m_lfsr); m_passed = 0;
          end else begin
            m_pl -= 4;
          end
        end
      end
      2: if (q_Stop) begin m_stop = 0; m_st = 3; end
      default: if (BtnC) begin
        m_ack = 1; m_st = 0; m_pl = 640; m_score = 0; m_passed = 0;
      end
    endcase
    m_lfsr = nl;
  endtask

  task automatic new_game();
    mode      = (games == 0) ? 0 : (games % 5);
    cap       = (games == 0) ? 44000 : $urandom_range(150, 900);
    bx        = (mode == 2) ? $urandom_range(0, 600) : 230;
    rst_at    = (games % 6 == 5) ? $urandom_range(5, 120) : -1;
    stop_wait = $urandom_range(0, 4);
    run_cyc   = 0;
  endtask

  task automatic set_inputs();
    int yt;
    q_Initial = (fc == 0) && ($urandom_range(0, 3) != 0);
    q_Flight  = (fc == 1);
    q_Stop    = (fc == 2);
    BtnC = (m_st == 0 || m_st == 3) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 15) == 0);
    case (mode)
      0, 4:    yt = m_gt + 10;
      1:       yt = 220;
      2:       yt = $urandom_range(60, 520);
      default: yt = 617;
    endcase
    // Force a floor crash on the exact cycle the pipe would score.
    if (mode == 4 && m_st == 1 && (m_pl + 39) < bx && !m_passed) yt = 617;
    if (run_cyc >= cap) yt = 617;
    Bird_X_L = 10'(bx);
    Bird_X_R = 10'(bx + 19);
    Bird_Y_T = 10'(yt);
    Bird_Y_B = 10'(yt + 19);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    model_step();
    exp_q.push_back(model_view());
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {Start, Ack, Stop, Pipe_X_L, Pipe_X_R, Gap_Y_T, Gap_Y_B, Score,
               {q_Done, q_Hit, q_Run, q_Idle}};
      vectors++;
      if (mon_a !== mon_e) begin
        miscompares++;
        $display("FAIL vec%0d t=%0t got start=%b ack=%b stop=%b pipe=%0d..%0d gap=%0d..%0d score=%0d st=%b exp start=%b ack=%b stop=%b pipe=%0d..%0d gap=%0d..%0d score=%0d st=%b",
                 vectors, $time, mon_a.start, mon_a.ack, mon_a.stop, mon_a.pl, mon_a.pr,
                 mon_a.gt, mon_a.gb, mon_a.score, mon_a.st, mon_e.start, mon_e.ack,
                 mon_e.stop, mon_e.pl, mon_e.pr, mon_e.gt, mon_e.gb, mon_e.score, mon_e.st);
      end
    end
  end

  initial begin
    #1500000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    reset = 1'b1;
    BtnC = 1'b0; q_Initial = 1'b1; q_Flight = 1'b0; q_Stop = 1'b0;
    Bird_X_L = 10'd230; Bird_X_R = 10'd249; Bird_Y_T = 10'd280; Bird_Y_B = 10'd299;
    model_reset();
    exp_q.push_back(model_view());
    @(negedge Clk);
    #1;
    reset = 1'b0;
    fc = 0; games = 0; total = 0;
    new_game();

    while (games < 24 && total < 90000) begin
      set_inputs();
      step();
      total++;
      if (m_st == 1) run_cyc++;
      if (rst_at >= 0 && m_st == 1 && run_cyc == rst_at) begin
        // Asynchronous reset between edges: the pending expectation is never
        // observed, the reset values must appear before the next edge.
        #1;
        reset = 1'b1;
        dummy = exp_q.pop_back();
        model_reset();
        exp_q.push_back(model_view());
        #1;
        reset = 1'b0;
        fc = 0;
        games++;
        new_game();
      end else begin
        if (m_start) fc = 1;
        if (m_st == 2 && fc == 1) begin
          if (stop_wait == 0) fc = 2;
          else stop_wait--;
        end
        if (m_st == 3 && fc == 2 && $urandom_range(0, 9) == 0) fc = 0;
        if (m_ack) begin
          fc = 0;
          games++;
          new_game();
        end
      end
    end

    @(negedge Clk);
    @(negedge Clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations never checked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_collision_ctrl.md
# pipe_collision_ctrl

Game supervisor that sits opposite the bird flight controller. It consumes the bird bounding box and the controller's one-hot state, and drives the controller's `Start`, `Stop` and `Ack` inputs. It scrolls a single pipe obstacle with a pseudo-random gap, detects bird/pipe and bird/floor collisions, and keeps the score. It also provides pipe geometry and score to the VGA and display logic.

## Interface
- `PIPE_STEP`, 4: pixels the pipe moves left per `Clk` in run.
- `PIPE_W`, 40: pipe width in pixels.
- `SCREEN_W`, 640: respawn/start X of the pipe left edge.
- `GAP_MIN_Y`, 100: minimum gap top.
- `GAP_H`, 120: gap height in pixels.
- `FLOOR_Y`, 636: bird bottom at or below this value is a crash.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.

- `Clk`  in  1: system clock (same game-rate clock as the flight controller).
- `reset`  in  1: asynchronous, active-high.
- `BtnC`  in  1: debounced single-cycle press; used as start and acknowledge.
- `q_Initial`, `q_Flight`, `q_Stop`  in  1 each: flight controller state.
- `Bird_X_L`, `Bird_X_R`, `Bird_Y_T`, `Bird_Y_B`  in  10 each: bird box, inclusive.
- `Start`, `Ack`  out  1: single-cycle pulses to the flight controller.
- `Stop`  out  1: level to the flight controller.
- `Pipe_X_L`, `Pipe_X_R`  out  10: pipe horizontal extent, inclusive.
- `Gap_Y_T`, `Gap_Y_B`  out  10: gap vertical extent, inclusive.
- `Score`  out  8: pipes passed, saturating.
- `q_Idle`, `q_Run`, `q_Hit`, `q_Done`  out  1: one-hot state of this block.

## Operation
- One-hot FSM with four states: QIdle, QRun, QHit, QDone.
- **QIdle**
  - Pipe held at `Pipe_X_L=SCREEN_W` and `Pipe_X_R=SCREEN_W+PIPE_W-1`; `Score` held at 0.
  - When `BtnC & q_Initial`: `Start`=1 for one cycle, then go to QRun.
  - `BtnC` without `q_Initial` is ignored.
- **QRun, each cycle, in priority order:**
  1. Crash check on the current registered values.
     - Crash is X overlap (`Bird_X_R>=Pipe_X_L && Bird_X_L<=Pipe_X_R`) with `Bird_Y_T<Gap_Y_T || Bird_Y_B>Gap_Y_B`, or `Bird_Y_B>=FLOOR_Y`.
     - On crash: `Stop`<=1, go to QHit. Pipe and score do not update that cycle.
  2. Respawn when `Pipe_X_R<PIPE_STEP`.
     - `Pipe_X_L`<=`SCREEN_W`, `Pipe_X_R`<=`SCREEN_W+PIPE_W-1`.
     - `Gap_Y_T`<=`GAP_MIN_Y+{2'b0,lfsr}`, `Gap_Y_B`<=`Gap_Y_T_new+GAP_H-1`.
     - Clear the passed flag.
  3. Otherwise both pipe X edges decrement by `PIPE_STEP`.
  4. Score:
     - When `Pipe_X_R<Bird_X_L` and the passed flag is clear, `Score` += 1, saturating at 255, and the passed flag is set.
     - This may coincide with step 2 or 3.
- **QHit:** `Stop` held at 1 and the pipe frozen. On `q_Stop`: `Stop`<=0, go to QDone.
- **QDone:**
  - Pipe, gap and `Score` frozen for display.
  - On `BtnC`: `Ack`=1 for one cycle, then go to QIdle.
- **LFSR:** 8-bit Fibonacci, taps 8,6,5,4. It advances every cycle in every state and never locks at zero.
- **Width rules:** all arithmetic is 10-bit unsigned. With the defaults, no sum exceeds 1023: max `Gap_Y_B` = 474, max `Pipe_X_R` = 679. Respawn happens before `Pipe_X_R` can underflow.
- **Illegal FSM encoding:** recover to QIdle with all outputs at reset values.

## Timing
- **Reset values:**
  - QIdle; `Start`=`Ack`=`Stop`=0; `Score`=0.
  - `Pipe_X_L`=640, `Pipe_X_R`=679.
  - lfsr=`LFSR_SEED`; `Gap_Y_T`=`GAP_MIN_Y+SEED` (265), `Gap_Y_B`=384.
- All outputs are registered.
- `Start` goes high the cycle after `BtnC` is sampled in QIdle. The flight controller reaches `q_Flight` one cycle later.
- `Stop` goes high the cycle after the crash condition is true. It stays high until `q_Stop` is sampled, and drops the following cycle.
- `Ack` goes high the cycle after `BtnC` is sampled in QDone. It is one cycle wide.
- If `q_Initial` is already asserted (e.g. the controller was reset alone), QDone still requires `BtnC`.
- Reset mid-game: everything returns to reset values immediately (asynchronous). The LFSR reseeds.
- Bird inputs are sampled as-is. The flight controller updates them on the same `Clk` edge, so collision uses the previous-cycle bird box.

## Test plan
- **Start handshake:** reset, `q_Initial`=1, pulse `BtnC` -> `Start` high exactly 1 cycle; `q_Run`; `Pipe_X_L` 640→636→632 on successive cycles.
- **Pass and score:** bird X 230..249, Y 280..299, gap 265..384 -> no `Stop`; `Score` becomes 1 in the cycle after `Pipe_X_R` falls below 230; no second increment for the same pipe.
- **Respawn:** run until `Pipe_X_R`<4 -> next cycle `Pipe_X_L`=640, `Pipe_X_R`=679, `Gap_Y_B-Gap_Y_T`=119, new gap differs from the previous one.
- **Pipe crash:** bird Y 220..239 with gap 265..384 -> `Stop`=1 one cycle after `Pipe_X_L`<=249; pipe frozen; drive `q_Stop` -> `Stop`=0, `q_Done`; `BtnC` -> one-cycle `Ack`, `q_Idle`, `Score`=0.
- **Floor crash:** bird `Y_B`=636, no X overlap -> `Stop` next cycle.
- **Simultaneous and reset:**
  - Crash and score in the same cycle -> `Score` unchanged.
  - Assert `reset` mid-QRun -> all outputs at reset values before the next edge.
